// File: rtl/mult_seq_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state
// encoding and the default operand width used by ALU and HI/LO users.
package mult_seq_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_seq_if.sv
// START/BUSY/DONE handshake plus operand and HI/LO result bus between the
// datapath control unit (master) and the multiplier (slave).
interface mult_seq_if
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic             START;
  logic             SIGNED;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output START, SIGNED, A, B,
    input  BUSY, DONE, HI, LO
  );

  modport slave (
    input  START, SIGNED, A, B,
    output BUSY, DONE, HI, LO
  );

endinterface

// File: rtl/mult_abs_neg.sv
// Conditional two's-complement negate; used both for operand magnitudes
// and for applying the sign to the unsigned product.
module mult_abs_neg #(
  parameter int N = 8
) (
  input  logic         en_i,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] out_o
);

  assign out_o = en_i ? -in_i : in_i;

endmodule

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier: multiplies operand magnitudes one bit per
// cycle over WIDTH cycles, then applies the sign in a final FIX cycle.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic       CLK,
  input  logic       RST,
  mult_seq_if.slave  mul
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mag_a_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic                 done_q;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   acc_d;

  mult_abs_neg #(.N(WIDTH)) u_abs_a (
    .en_i  (mul.SIGNED & mul.A[WIDTH-1]),
    .in_i  (mul.A),
    .out_o (abs_a)
  );

  mult_abs_neg #(.N(WIDTH)) u_abs_b (
    .en_i  (mul.SIGNED & mul.B[WIDTH-1]),
    .in_i  (mul.B),
    .out_o (abs_b)
  );

  mult_abs_neg #(.N(2*WIDTH)) u_sign_fix (
    .en_i  (neg_q),
    .in_i  (acc_q),
    .out_o (prod_fix)
  );

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    acc_d = {sum_d, acc_q[WIDTH-1:1]};
  end

  // NOTE: all state uses non-blocking assignments and is cleared by the async reset,
  // so an operation in flight is abandoned without a DONE pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mag_a_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (mul.START) begin
            mag_a_q <= abs_a;
            acc_q   <= {{WIDTH{1'b0}}, abs_b};
            neg_q   <= mul.SIGNED & (mul.A[WIDTH-1] ^ mul.B[WIDTH-1]);
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          {hi_q, lo_q} <= prod_fix;
          done_q       <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul.BUSY = (state_q != S_IDLE);
  assign mul.DONE = done_q;
  assign mul.HI   = hi_q;
  assign mul.LO   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq at WIDTH=32 and WIDTH=8: a cycle-level
// reference model built on plain integer multiplication, plus directed literals.
module tb_mult_seq;

  logic clk = 1'b0;
  logic rst32_n = 1'b0;
  logic rst8_n  = 1'b0;
  bit   mon_en  = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_seq_if #(.WIDTH(32)) m32 ();
  mult_seq_if #(.WIDTH(8))  m8 ();

  mult_seq #(.WIDTH(32)) u_dut32 (.CLK(clk), .RST(rst32_n), .mul(m32));
  mult_seq #(.WIDTH(8))  u_dut8  (.CLK(clk), .RST(rst8_n),  .mul(m8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference products from plain integer arithmetic.
  function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return 16'(sa * sb);
    end
    return {8'b0, a} * {8'b0, b};
  endfunction

  // Behavioural model: an accepted request yields its product WIDTH+1 edges later.
  int          left32, left8;
  logic [63:0] pend32, hilo32;
  logic [15:0] pend8, hilo8;
  bit          done32m, done8m;

  always @(posedge clk or negedge rst32_n) begin
    if (!rst32_n) begin
      left32 <= 0; done32m <= 1'b0; hilo32 <= '0; pend32 <= '0;
    end else begin
      done32m <= 1'b0;
      if (left32 == 0) begin
        if (m32.START) begin
          left32 <= 33;
          pend32 <= ref32(m32.SIGNED, m32.A, m32.B);
        end
      end else begin
        left32 <= left32 - 1;
        if (left32 == 1) begin
          done32m <= 1'b1;
          hilo32  <= pend32;
        end
      end
    end
  end

  always @(posedge clk or negedge rst8_n) begin
    if (!rst8_n) begin
      left8 <= 0; done8m <= 1'b0; hilo8 <= '0; pend8 <= '0;
    end else begin
      done8m <= 1'b0;
      if (left8 == 0) begin
        if (m8.START) begin
          left8 <= 9;
          pend8 <= ref8(m8.SIGNED, m8.A, m8.B);
        end
      end else begin
        left8 <= left8 - 1;
        if (left8 == 1) begin
          done8m <= 1'b1;
          hilo8  <= pend8;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy32", 64'(m32.BUSY), 64'(left32 != 0));
      check("done32", 64'(m32.DONE), 64'(done32m));
      check("hilo32", {m32.HI, m32.LO}, hilo32);
      check("busy8",  64'(m8.BUSY), 64'(left8 != 0));
      check("done8",  64'(m8.DONE), 64'(done8m));
      check("hilo8",  64'({m8.HI, m8.LO}), 64'(hilo8));
    end
  end

  // Drives a request at the current negedge; returns at the negedge after the sampling edge.
  task automatic start_op(input bit w8, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      m8.START = 1'b1; m8.SIGNED = s; m8.A = a[7:0]; m8.B = b[7:0];
    end else begin
      m32.START = 1'b1; m32.SIGNED = s; m32.A = a; m32.B = b;
    end
    @(posedge clk);
    @(negedge clk);
    if (w8) m8.START = 1'b0;
    else    m32.START = 1'b0;
  endtask

  task automatic wait_done(input bit w8, output int lat, output int bcnt);
    lat  = 0;
    bcnt = (w8 ? m8.BUSY : m32.BUSY) ? 1 : 0;
    while (!(w8 ? m8.DONE : m32.DONE) && lat < 200) begin
      @(negedge clk);
      lat++;
      if (w8 ? m8.BUSY : m32.BUSY) bcnt++;
    end
  endtask

  task automatic run_op(input bit w8, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    int lat, bcnt, w;
    w = w8 ? 8 : 32;
    @(negedge clk);
    start_op(w8, s, a, b);
    wait_done(w8, lat, bcnt);
    check({nm, "_lat"},  64'(lat),  64'(w + 1));
    check({nm, "_busy"}, 64'(bcnt), 64'(w + 1));
    check({nm, "_hi"}, 64'(w8 ? 32'(m8.HI) : m32.HI), 64'(eh));
    check({nm, "_lo"}, 64'(w8 ? 32'(m8.LO) : m32.LO), 64'(el));
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return mask;
      2:       return 32'd1 << (w - 1);
      3:       return 32'd1;
      default: return $urandom & mask;
    endcase
  endfunction

  initial begin
    int lat, bcnt, seen, c_done;
    m32.START = 1'b0; m32.SIGNED = 1'b0; m32.A = '0; m32.B = '0;
    m8.START  = 1'b0; m8.SIGNED  = 1'b0; m8.A  = '0; m8.B  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy32", 64'(m32.BUSY), 64'd0);
    check("rst_done32", 64'(m32.DONE), 64'd0);
    check("rst_hilo32", {m32.HI, m32.LO}, 64'd0);
    check("rst_hilo8",  64'({m8.HI, m8.LO}), 64'd0);
    rst32_n = 1'b1;
    rst8_n  = 1'b1;
    mon_en  = 1'b1;

    // Directed WIDTH=32 products.
    run_op(0, 0, 32'd5, 32'd20, 32'h0, 32'd100, "u_5x20");
    run_op(0, 1, -32'sd5, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FF9C, "s_m5x20");
    run_op(0, 1, -32'sd5, -32'sd20, 32'h0, 32'd100, "s_m5xm20");
    run_op(0, 0, 32'd2147483647, 32'd203, 32'h0000_0065, 32'h7FFF_FF35, "u_max_x203");
    run_op(0, 0, 32'd4000000000, 32'd2, 32'h1, 32'hDCD6_5000, "u_4e9x2");
    run_op(0, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "s_minxmin");
    run_op(0, 1, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, "s_minx1");
    run_op(0, 1, 32'd0, -32'sd7, 32'h0, 32'h0, "s_0xm7");

    // START while busy is ignored; the original operands still produce the result.
    @(negedge clk);
    start_op(0, 0, 32'd1000, 32'd1000);
    repeat (3) @(negedge clk);
    m32.START = 1'b1; m32.A = 32'd3; m32.B = 32'd4;
    @(negedge clk);
    m32.START = 1'b0;
    wait_done(0, lat, bcnt);
    check("ign_hi", 64'(m32.HI), 64'd0);
    check("ign_lo", 64'(m32.LO), 64'd1000000);

    // Back-to-back: START in the DONE cycle is accepted.
    c_done = cyc;
    start_op(0, 1, -32'sd7, 32'd9);
    wait_done(0, lat, bcnt);
    check("b2b_gap", 64'(cyc - c_done), 64'd34);
    check("b2b_hilo", {m32.HI, m32.LO}, 64'hFFFF_FFFF_FFFF_FFC1);

    // Reset before iteration 10 aborts the operation.
    @(negedge clk);
    start_op(0, 0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    rst32_n = 1'b0;
    #1;
    check("arst_busy", 64'(m32.BUSY), 64'd0);
    check("arst_done", 64'(m32.DONE), 64'd0);
    check("arst_hilo", {m32.HI, m32.LO}, 64'd0);
    repeat (2) @(negedge clk);
    rst32_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (m32.DONE) seen++;
    end
    check("arst_no_done", 64'(seen), 64'd0);
    run_op(0, 0, 32'd7, 32'd6, 32'h0, 32'd42, "post_rst");

    // Directed WIDTH=8 products.
    run_op(1, 0, 32'd5, 32'd20, 32'h0, 32'h64, "w8_u_5x20");
    run_op(1, 1, -32'sd128, -32'sd128, 32'h40, 32'h00, "w8_s_minxmin");
    run_op(1, 1, 32'h80, 32'd1, 32'hFF, 32'h80, "w8_s_minx1");

    // Random traffic on both widths, including requests while busy.
    repeat (2500) begin
      @(negedge clk);
      m32.START  = ($urandom_range(0, 3) == 0);
      m32.SIGNED = 1'($urandom_range(0, 1));
      m32.A      = pick(32);
      m32.B      = pick(32);
      m8.START   = ($urandom_range(0, 3) == 0);
      m8.SIGNED  = 1'($urandom_range(0, 1));
      m8.A       = 8'(pick(8));
      m8.B       = 8'(pick(8));
    end
    @(negedge clk);
    m32.START = 1'b0;
    m8.START  = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
